// File: rtl/prog_data_mem.sv
// -----------------------------------------------------------------------------
// prog_data_mem
//
// Program/data memory that sits beside a small CPU.  A host loader streams the
// program in as bytes (little-endian pairs) over a valid/ready handshake.  Once
// the final byte arrives, or the instruction store fills, the block switches
// to RUN.  In RUN it releases the CPU (EN_L=0), serves instruction fetches and
// handles data loads and stores.
//
// Handshake: a loader byte is transferred on a rising CLK edge where
// LD_VALID=1 and LD_READY=1.  LD_DATA/LD_LAST are only looked at on such an
// edge.  LD_READY depends only on the current state and not on LD_VALID.
//
// Ports
//   CLK         in   1   rising-edge clock
//   RESET       in   1   synchronous active-low reset
//   PC          in   8   instruction byte address (PC[0] ignored)
//   Iin         out 16   instruction word (16'h0001 = HALT outside RUN)
//   ADDR        in   8   data address
//   WDATA       in   8   store data
//   MW          in   1   store strobe (honoured in RUN only)
//   Din         out  8   load data, combinational read of data[ADDR]
//   EN_L        out  1   CPU run enable, active-low
//   LD_VALID    in   1   loader byte valid
//   LD_DATA     in   8   loader byte
//   LD_LAST     in   1   final program byte marker
//   LD_READY    out  1   loader can accept a byte
//   LD_RESTART  in   1   return from RUN to load mode
//   WORD_CNT    out  8   instruction words written since load start
//   o_dbg_state out  2   loader FSM state (debug visibility)
// -----------------------------------------------------------------------------
module prog_data_mem (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  PC,
    output logic [15:0] Iin,
    input  logic [7:0]  ADDR,
    input  logic [7:0]  WDATA,
    input  logic        MW,
    output logic [7:0]  Din,
    output logic        EN_L,
    input  logic        LD_VALID,
    input  logic [7:0]  LD_DATA,
    input  logic        LD_LAST,
    output logic        LD_READY,
    input  logic        LD_RESTART,
    output logic [7:0]  WORD_CNT,
    output logic [1:0]  o_dbg_state
);

    // IDLE doubles as "waiting for the low byte" of the next word.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GET_HI = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;

    localparam logic [15:0] HALT_WORD = 16'h0001;

    logic [1:0]  r_state;
    logic [7:0]  r_ptr;      // 0..128; reaches 128 only together with RUN
    logic [7:0]  r_low;

    logic [15:0] r_instr [128];
    logic [7:0]  r_data  [256];

    logic        w_run;
    logic        w_ld_ready;
    logic        w_accept;
    logic        w_instr_we;
    logic [15:0] w_instr_wdata;
    logic        w_data_we;
    logic        w_pc_unused;

    assign w_run      = (r_state == S_RUN);
    assign w_ld_ready = (r_state == S_IDLE) || (r_state == S_GET_HI);
    assign w_accept   = LD_VALID && w_ld_ready;

    // A word is written either when its high byte arrives, or when the low
    // byte of a new pair is flagged as last (high byte padded with zero).
    // Reset suppresses every write so a mid-load reset leaves memory intact.
    assign w_instr_we    = RESET && w_accept &&
                           ((r_state == S_GET_HI) || LD_LAST);
    assign w_instr_wdata = (r_state == S_GET_HI) ? {LD_DATA, r_low}
                                                 : {8'h00, LD_DATA};

    assign w_data_we = RESET && w_run && MW;

    // Word-addressed fetch: the LSB of the byte address carries no information.
    assign w_pc_unused = PC[0];

    // -------------------------------------------------------------------------
    // Loader FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_ptr   <= 8'd0;
            r_low   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (LD_VALID) begin
                        if (LD_LAST) begin
                            r_ptr   <= r_ptr + 8'd1;
                            r_state <= S_RUN;
                        end else begin
                            r_low   <= LD_DATA;
                            r_state <= S_GET_HI;
                        end
                    end
                end
                S_GET_HI: begin
                    if (LD_VALID) begin
                        r_ptr <= r_ptr + 8'd1;
                        // Writing the last slot ends the load; ptr never wraps.
                        if (LD_LAST || (r_ptr == 8'd127)) begin
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_RUN: begin
                    if (LD_RESTART) begin
                        r_state <= S_IDLE;
                        r_ptr   <= 8'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Memories (never cleared by reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_instr_we) begin
            r_instr[r_ptr[6:0]] <= w_instr_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_data_we) begin
            r_data[ADDR] <= WDATA;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign Iin         = w_run ? r_instr[PC[7:1]] : HALT_WORD;
    assign EN_L        = !w_run;
    assign Din         = r_data[ADDR];
    assign LD_READY    = w_ld_ready;
    assign WORD_CNT    = r_ptr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prog_data_mem.sv
// -----------------------------------------------------------------------------
// tb_prog_data_mem
//
// Bench for prog_data_mem.  A reference model holds the program as a word
// array filled from the byte stream (pairs, little-endian), the data store as
// a byte array, and a run flag.  The model is advanced once per clock from the
// inputs applied for that edge.  Outputs are compared 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_prog_data_mem;

    logic        CLK;
    logic        RESET;
    logic [7:0]  PC;
    logic [15:0] Iin;
    logic [7:0]  ADDR;
    logic [7:0]  WDATA;
    logic        MW;
    logic [7:0]  Din;
    logic        EN_L;
    logic        LD_VALID;
    logic [7:0]  LD_DATA;
    logic        LD_LAST;
    logic        LD_READY;
    logic        LD_RESTART;
    logic [7:0]  WORD_CNT;
    logic [1:0]  o_dbg_state;

    prog_data_mem dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PC         (PC),
        .Iin        (Iin),
        .ADDR       (ADDR),
        .WDATA      (WDATA),
        .MW         (MW),
        .Din        (Din),
        .EN_L       (EN_L),
        .LD_VALID   (LD_VALID),
        .LD_DATA    (LD_DATA),
        .LD_LAST    (LD_LAST),
        .LD_READY   (LD_READY),
        .LD_RESTART (LD_RESTART),
        .WORD_CNT   (WORD_CNT),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- reference model ----------------
    logic [15:0] m_instr [128];
    bit          m_iv    [128];
    logic [7:0]  m_data  [256];
    bit          m_dv    [256];
    int          m_ptr;
    bit          m_run;
    bit          m_have;
    logic [7:0]  m_low;

    int n_vec;
    int n_err;

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_edge();
        if (!RESET) begin
            m_run  = 0;
            m_have = 0;
            m_ptr  = 0;
        end else if (m_run) begin
            if (MW) begin
                m_data[ADDR] = WDATA;
                m_dv[ADDR]   = 1;
            end
            if (LD_RESTART) begin
                m_run  = 0;
                m_have = 0;
                m_ptr  = 0;
            end
        end else if (LD_VALID) begin
            if (!m_have) begin
                if (LD_LAST) begin
                    m_instr[m_ptr] = {8'h00, LD_DATA};
                    m_iv[m_ptr]    = 1;
                    m_ptr++;
                    m_run = 1;
                end else begin
                    m_low  = LD_DATA;
                    m_have = 1;
                end
            end else begin
                m_instr[m_ptr] = {LD_DATA, m_low};
                m_iv[m_ptr]    = 1;
                m_ptr++;
                m_have = 0;
                if (LD_LAST || m_ptr == 128) m_run = 1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        LD_VALID = 1'b1;
        LD_DATA  = b;
        LD_LAST  = last;
        tick();
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
        LD_DATA  = 8'($urandom);
    endtask

    task automatic do_restart();
        LD_RESTART = 1'b1;
        tick();
        LD_RESTART = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        n_vec++;
        if (EN_L !== 1'b1) begin
            n_err++; $display("FAIL reset_en_l: got %b want 1", EN_L);
        end
        n_vec++;
        if (LD_READY !== 1'b1) begin
            n_err++; $display("FAIL reset_ld_ready: got %b want 1", LD_READY);
        end
        n_vec++;
        if (Iin !== 16'h0001) begin
            n_err++; $display("FAIL reset_iin: got %h want 0001", Iin);
        end
        n_vec++;
        if (WORD_CNT !== 8'd0) begin
            n_err++; $display("FAIL reset_word_cnt: got %0d want 0", WORD_CNT);
        end
    endtask

    task automatic test_basic_load();
        send_byte(8'h34, 1'b0);
        n_vec++;
        if (LD_READY !== 1'b1 || EN_L !== 1'b1) begin
            n_err++; $display("FAIL basic_mid: ready=%b en_l=%b want 1/1", LD_READY, EN_L);
        end
        send_byte(8'h12, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b1);
        n_vec++;
        if (WORD_CNT !== 8'd2) begin
            n_err++; $display("FAIL basic_word_cnt: got %0d want 2", WORD_CNT);
        end
        n_vec++;
        if (EN_L !== 1'b0 || LD_READY !== 1'b0) begin
            n_err++; $display("FAIL basic_run: en_l=%b ready=%b want 0/0", EN_L, LD_READY);
        end
        PC = 8'd0; #1;
        n_vec++;
        if (Iin !== 16'h1234) begin
            n_err++; $display("FAIL basic_pc0: got %h want 1234", Iin);
        end
        PC = 8'd2; #1;
        n_vec++;
        if (Iin !== 16'h5678) begin
            n_err++; $display("FAIL basic_pc2: got %h want 5678", Iin);
        end
        PC = 8'd3; #1;
        n_vec++;
        if (Iin !== 16'h5678) begin
            n_err++; $display("FAIL basic_pc3_lsb_ignored: got %h want 5678", Iin);
        end
        PC = 8'd0;
    endtask

    task automatic test_data_store();
        logic [7:0] a;
        logic [7:0] old;
        // Fill the whole data store with random bytes.
        for (int i = 0; i < 256; i++) begin
            ADDR  = 8'(i);
            WDATA = 8'($urandom);
            MW    = 1'b1;
            tick();
        end
        MW = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom_range(0, 255));
            ADDR = a; #1;
            n_vec++;
            if (Din !== m_data[a]) begin
                n_err++; $display("FAIL data_read[%h]: got %h want %h", a, Din, m_data[a]);
            end
        end
        // Read-old during the write cycle, new value after the edge.
        ADDR  = 8'h10;
        old   = m_data[8'h10];
        WDATA = 8'h5A;
        MW    = 1'b1;
        #1;
        n_vec++;
        if (Din !== old) begin
            n_err++; $display("FAIL data_read_old: got %h want %h", Din, old);
        end
        tick();
        MW = 1'b0;
        n_vec++;
        if (Din !== 8'h5A) begin
            n_err++; $display("FAIL data_read_new: got %h want 5a", Din);
        end
    endtask

    task automatic test_restart();
        logic [7:0] v;
        logic [7:0] old;
        // Store and restart together: both take effect.
        v          = 8'($urandom);
        ADDR       = 8'h20;
        WDATA      = v;
        MW         = 1'b1;
        LD_RESTART = 1'b1;
        tick();
        MW         = 1'b0;
        LD_RESTART = 1'b0;
        n_vec++;
        if (EN_L !== 1'b1 || LD_READY !== 1'b1 || WORD_CNT !== 8'd0 || Iin !== 16'h0001) begin
            n_err++; $display("FAIL restart_state: en_l=%b ready=%b cnt=%0d iin=%h want 1/1/0/0001",
                              EN_L, LD_READY, WORD_CNT, Iin);
        end
        n_vec++;
        if (Din !== v) begin
            n_err++; $display("FAIL restart_store: got %h want %h", Din, v);
        end
        ADDR = 8'h10; #1;
        n_vec++;
        if (Din !== 8'h5A) begin
            n_err++; $display("FAIL restart_data_kept: got %h want 5a", Din);
        end
        // Store attempted outside RUN must be dropped.
        ADDR  = 8'h30;
        old   = m_data[8'h30];
        WDATA = ~old;
        MW    = 1'b1;
        tick();
        MW = 1'b0;
        n_vec++;
        if (Din !== old) begin
            n_err++; $display("FAIL idle_store_ignored: got %h want %h", Din, old);
        end
    endtask

    task automatic test_odd_last();
        send_byte(8'h01, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'hAA, 1'b1);
        n_vec++;
        if (WORD_CNT !== 8'd2 || EN_L !== 1'b0) begin
            n_err++; $display("FAIL odd_state: cnt=%0d en_l=%b want 2/0", WORD_CNT, EN_L);
        end
        PC = 8'd2; #1;
        n_vec++;
        if (Iin !== 16'h00AA) begin
            n_err++; $display("FAIL odd_word1: got %h want 00aa", Iin);
        end
        PC = 8'd0; #1;
        n_vec++;
        if (Iin !== 16'hF001) begin
            n_err++; $display("FAIL odd_word0: got %h want f001", Iin);
        end
        do_restart();
    endtask

    task automatic test_stall();
        logic [7:0] bytes [4];
        bytes[0] = 8'h34; bytes[1] = 8'h12; bytes[2] = 8'h78; bytes[3] = 8'h56;
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], (i == 3) ? 1'b1 : 1'b0);
            if (i < 3) begin
                // Noise on the ignored inputs while VALID is low.
                for (int g = 0; g < 3; g++) begin
                    LD_LAST    = 1'b1;
                    LD_RESTART = 1'b1;
                    LD_DATA    = 8'($urandom);
                    tick();
                    n_vec++;
                    if (LD_READY !== 1'b1 || EN_L !== 1'b1 || WORD_CNT !== 8'(m_ptr)) begin
                        n_err++; $display("FAIL stall_gap: ready=%b en_l=%b cnt=%0d want 1/1/%0d",
                                          LD_READY, EN_L, WORD_CNT, m_ptr);
                    end
                end
                LD_LAST    = 1'b0;
                LD_RESTART = 1'b0;
            end
        end
        PC = 8'd0; #1;
        n_vec++;
        if (Iin !== 16'h1234) begin
            n_err++; $display("FAIL stall_word0: got %h want 1234", Iin);
        end
        PC = 8'd2; #1;
        n_vec++;
        if (Iin !== 16'h5678 || WORD_CNT !== 8'd2) begin
            n_err++; $display("FAIL stall_word1: iin=%h cnt=%0d want 5678/2", Iin, WORD_CNT);
        end
        PC = 8'd0;
        do_restart();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 256; i++) begin
            send_byte(8'($urandom), 1'b0);
            if (i == 254) begin
                n_vec++;
                if (LD_READY !== 1'b1 || WORD_CNT !== 8'd127) begin
                    n_err++; $display("FAIL overflow_pre: ready=%b cnt=%0d want 1/127", LD_READY, WORD_CNT);
                end
            end
        end
        n_vec++;
        if (EN_L !== 1'b0 || LD_READY !== 1'b0 || WORD_CNT !== 8'd128) begin
            n_err++; $display("FAIL overflow_end: en_l=%b ready=%b cnt=%0d want 0/0/128",
                              EN_L, LD_READY, WORD_CNT);
        end
        // Further loader traffic in RUN must be ignored.
        for (int i = 0; i < 4; i++) begin
            LD_VALID = 1'b1;
            LD_LAST  = 1'($urandom);
            LD_DATA  = 8'($urandom);
            tick();
        end
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
        n_vec++;
        if (WORD_CNT !== 8'd128 || EN_L !== 1'b0) begin
            n_err++; $display("FAIL overflow_ignore: cnt=%0d en_l=%b want 128/0", WORD_CNT, EN_L);
        end
        for (int p = 0; p < 128; p++) begin
            PC = 8'(2 * p + int'($urandom_range(0, 1))); #1;
            n_vec++;
            if (Iin !== m_instr[p]) begin
                n_err++; $display("FAIL overflow_word[%0d]: got %h want %h", p, Iin, m_instr[p]);
            end
        end
        PC = 8'd0;
    endtask

    task automatic test_back_to_back();
        int nb;
        for (int it = 0; it < 3; it++) begin
            do_restart();
            nb = $urandom_range(3, 30);
            for (int i = 0; i < nb; i++) begin
                send_byte(8'($urandom), (i == nb - 1) ? 1'b1 : 1'b0);
                if ($urandom_range(0, 3) == 0) tick();
            end
            n_vec++;
            if (WORD_CNT !== 8'(m_ptr) || EN_L !== 1'b0) begin
                n_err++; $display("FAIL b2b_cnt[%0d]: cnt=%0d en_l=%b want %0d/0", it, WORD_CNT, EN_L, m_ptr);
            end
            // Words past the reload keep their older contents.
            for (int p = 0; p < 128; p++) begin
                PC = 8'(2 * p); #1;
                n_vec++;
                if (Iin !== m_instr[p]) begin
                    n_err++; $display("FAIL b2b_word[%0d][%0d]: got %h want %h", it, p, Iin, m_instr[p]);
                end
            end
        end
        PC = 8'd0;
    endtask

    task automatic test_reset_midload();
        logic [7:0] e;
        logic [7:0] old;
        do_restart();
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);      // now waiting for a high byte
        RESET    = 1'b0;
        LD_VALID = 1'b1;
        LD_DATA  = 8'($urandom);
        tick();
        RESET    = 1'b1;
        LD_VALID = 1'b0;
        n_vec++;
        if (WORD_CNT !== 8'd0 || LD_READY !== 1'b1 || EN_L !== 1'b1 || Iin !== 16'h0001) begin
            n_err++; $display("FAIL midload_reset: cnt=%0d ready=%b en_l=%b iin=%h want 0/1/1/0001",
                              WORD_CNT, LD_READY, EN_L, Iin);
        end
        e = 8'($urandom);
        send_byte(e, 1'b1);
        n_vec++;
        if (WORD_CNT !== 8'd1 || EN_L !== 1'b0) begin
            n_err++; $display("FAIL midload_reload: cnt=%0d en_l=%b want 1/0", WORD_CNT, EN_L);
        end
        PC = 8'd0; #1;
        n_vec++;
        if (Iin !== {8'h00, e}) begin
            n_err++; $display("FAIL midload_word0: got %h want %h", Iin, {8'h00, e});
        end
        PC = 8'd2; #1;
        n_vec++;
        if (Iin !== m_instr[1]) begin
            n_err++; $display("FAIL midload_no_write: got %h want %h", Iin, m_instr[1]);
        end
        PC = 8'd0;
        // Reset beats a store in the same cycle.
        ADDR  = 8'h40;
        old   = m_data[8'h40];
        WDATA = ~old;
        MW    = 1'b1;
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        MW    = 1'b0;
        n_vec++;
        if (Din !== old || EN_L !== 1'b1) begin
            n_err++; $display("FAIL reset_over_store: din=%h en_l=%b want %h/1", Din, EN_L, old);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        n_vec      = 0;
        n_err      = 0;
        m_ptr      = 0;
        m_run      = 0;
        m_have     = 0;
        m_low      = 8'h00;
        for (int i = 0; i < 128; i++) m_iv[i] = 0;
        for (int i = 0; i < 256; i++) m_dv[i] = 0;
        RESET      = 1'b0;
        PC         = 8'd0;
        ADDR       = 8'd0;
        WDATA      = 8'd0;
        MW         = 1'b0;
        LD_VALID   = 1'b0;
        LD_DATA    = 8'd0;
        LD_LAST    = 1'b0;
        LD_RESTART = 1'b0;
        #1;

        test_reset();
        test_basic_load();
        test_data_store();
        test_restart();
        test_odd_last();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_reset_midload();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
